// File: rtl/obstacle_mover_if.sv
// Control and status bundle for obstacle_mover: spawn/kill/halt requests in,
// per-channel activity, packed positions and tick/exit pulses out.
interface obstacle_mover_if #(
    parameter int N_OBJ   = 4,
    parameter int COORD_W = 10,
    parameter int IDX_W   = 2
);
    logic                       halt;
    logic                       spawn;
    logic [IDX_W-1:0]           spawn_id;
    logic [COORD_W-1:0]         spawn_x;
    logic [COORD_W-1:0]         spawn_y;
    logic [3:0]                 spawn_dx;
    logic [3:0]                 spawn_dy;
    logic [N_OBJ-1:0]           kill;
    logic [N_OBJ-1:0]           active;
    logic [N_OBJ*COORD_W-1:0]   x_pos;
    logic [N_OBJ*COORD_W-1:0]   y_pos;
    logic                       tick;
    logic [N_OBJ-1:0]           exit_evt;

    modport master (
        output halt, spawn, spawn_id, spawn_x, spawn_y, spawn_dx, spawn_dy, kill,
        input  active, x_pos, y_pos, tick, exit_evt
    );

    modport slave (
        input  halt, spawn, spawn_id, spawn_x, spawn_y, spawn_dx, spawn_dy, kill,
        output active, x_pos, y_pos, tick, exit_evt
    );
endinterface

// File: rtl/obstacle_mover.sv
// N_OBJ independent obstacle channels stepped by a shared prescaler tick;
// each channel either wraps at the screen edge or retires with an exit pulse.
module obstacle_mover #(
    parameter int N_OBJ     = 4,
    parameter int COORD_W   = 10,
    parameter int TICK_DIV  = 251250,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int WRAP_MODE = 1,
    parameter int IDX_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    obstacle_mover_if.slave   bus
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW2   = COORD_W + 2;

    typedef logic signed [CW2-1:0] wide_t;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
    localparam wide_t              X_LIM     = wide_t'(X_MAX);
    localparam wide_t              Y_LIM     = wide_t'(Y_MAX);
    localparam wide_t              X_SPAN    = wide_t'(X_MAX + 1);
    localparam wide_t              Y_SPAN    = wide_t'(Y_MAX + 1);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tick_q;
    logic                     step_en;
    logic [COORD_W-1:0]       spawn_x_clamp, spawn_y_clamp;
    logic [N_OBJ-1:0]         act_vec, exit_vec;
    logic [N_OBJ*COORD_W-1:0] x_vec, y_vec;

    // step_en marks the edge on which channels move; tick_q shows it a cycle later
    always_comb begin
        step_en = !bus.halt && (cnt_q == CNT_LAST);
        cnt_d   = cnt_q;
        if (!bus.halt) begin
            cnt_d = step_en ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= step_en;
        end
    end

    assign spawn_x_clamp = (bus.spawn_x > X_MAX_C) ? X_MAX_C : bus.spawn_x;
    assign spawn_y_clamp = (bus.spawn_y > Y_MAX_C) ? Y_MAX_C : bus.spawn_y;

    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_ch
        logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
        logic [3:0]         dx_q, dx_d, dy_q, dy_d;
        logic               act_q, act_d, exit_q, exit_d;
        logic               spawn_hit;
        wide_t              x_sum, y_sum;
        logic [COORD_W-1:0] x_wrap, y_wrap;
        logic               out_of_range;

        // ids >= N_OBJ never match any channel, so they are silently dropped
        assign spawn_hit = bus.spawn && (bus.spawn_id == IDX_W'(gi));

        always_comb begin
            x_sum = wide_t'({2'b00, x_q}) + wide_t'($signed(dx_q));
            y_sum = wide_t'({2'b00, y_q}) + wide_t'($signed(dy_q));

            if (x_sum[CW2-1])      x_wrap = COORD_W'(x_sum + X_SPAN);
            else if (x_sum > X_LIM) x_wrap = COORD_W'(x_sum - X_SPAN);
            else                    x_wrap = COORD_W'(x_sum);

            if (y_sum[CW2-1])      y_wrap = COORD_W'(y_sum + Y_SPAN);
            else if (y_sum > Y_LIM) y_wrap = COORD_W'(y_sum - Y_SPAN);
            else                    y_wrap = COORD_W'(y_sum);

            out_of_range = x_sum[CW2-1] || (x_sum > X_LIM) ||
                           y_sum[CW2-1] || (y_sum > Y_LIM);
        end

        always_comb begin
            x_d    = x_q;
            y_d    = y_q;
            dx_d   = dx_q;
            dy_d   = dy_q;
            act_d  = act_q;
            exit_d = 1'b0;
            if (bus.kill[gi]) begin
                x_d   = '0;
                y_d   = '0;
                dx_d  = '0;
                dy_d  = '0;
                act_d = 1'b0;
            end else if (spawn_hit) begin
                x_d   = spawn_x_clamp;
                y_d   = spawn_y_clamp;
                dx_d  = bus.spawn_dx;
                dy_d  = bus.spawn_dy;
                act_d = 1'b1;
            end else if (act_q && step_en) begin
                if (WRAP_MODE != 0) begin
                    x_d = x_wrap;
                    y_d = y_wrap;
                end else if (out_of_range) begin
                    x_d    = '0;
                    y_d    = '0;
                    dx_d   = '0;
                    dy_d   = '0;
                    act_d  = 1'b0;
                    exit_d = 1'b1;
                end else begin
                    x_d = COORD_W'(x_sum);
                    y_d = COORD_W'(y_sum);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                x_q    <= '0;
                y_q    <= '0;
                dx_q   <= '0;
                dy_q   <= '0;
                act_q  <= 1'b0;
                exit_q <= 1'b0;
            end else begin
                x_q    <= x_d;
                y_q    <= y_d;
                dx_q   <= dx_d;
                dy_q   <= dy_d;
                act_q  <= act_d;
                exit_q <= exit_d;
            end
        end

        assign act_vec[gi]                    = act_q;
        assign exit_vec[gi]                   = exit_q;
        assign x_vec[gi*COORD_W +: COORD_W]   = x_q;
        assign y_vec[gi*COORD_W +: COORD_W]   = y_q;
    end

    assign bus.active   = act_vec;
    assign bus.exit_evt = exit_vec;
    assign bus.x_pos    = x_vec;
    assign bus.y_pos    = y_vec;
    assign bus.tick     = tick_q;

endmodule

// File: tb/tb_obstacle_mover.sv
// Drives a wrap-mode (4 channels) and a retire-mode (3 channels) instance with
// shared stimulus and compares both against an integer reference model.
module tb_obstacle_mover;
    localparam int TDIV = 4;
    localparam int XMAX = 639;
    localparam int YMAX = 479;

    logic       clk = 1'b0;
    logic       rst, halt, spawn;
    logic [1:0] sid;
    logic [9:0] sx, sy;
    logic [3:0] sdx, sdy;
    logic [3:0] kill;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obstacle_mover_if #(.N_OBJ(4), .COORD_W(10), .IDX_W(2)) ifa ();
    obstacle_mover_if #(.N_OBJ(3), .COORD_W(10), .IDX_W(2)) ifb ();

    assign ifa.halt = halt;  assign ifb.halt = halt;
    assign ifa.spawn = spawn; assign ifb.spawn = spawn;
    assign ifa.spawn_id = sid; assign ifb.spawn_id = sid;
    assign ifa.spawn_x = sx; assign ifb.spawn_x = sx;
    assign ifa.spawn_y = sy; assign ifb.spawn_y = sy;
    assign ifa.spawn_dx = sdx; assign ifb.spawn_dx = sdx;
    assign ifa.spawn_dy = sdy; assign ifb.spawn_dy = sdy;
    assign ifa.kill = kill;  assign ifb.kill = kill[2:0];

    obstacle_mover #(.N_OBJ(4), .COORD_W(10), .TICK_DIV(TDIV), .X_MAX(XMAX),
                     .Y_MAX(YMAX), .WRAP_MODE(1), .IDX_W(2)) dut_wrap (
        .clk(clk), .reset(rst), .bus(ifa.slave));

    obstacle_mover #(.N_OBJ(3), .COORD_W(10), .TICK_DIV(TDIV), .X_MAX(XMAX),
                     .Y_MAX(YMAX), .WRAP_MODE(0), .IDX_W(2)) dut_ret (
        .clk(clk), .reset(rst), .bus(ifb.slave));

    // Reference model: index 0 = wrap instance, 1 = retire instance
    int px[2][4], py[2][4], vx[2][4], vy[2][4];
    bit act[2][4], ex[2][4];
    int cnt;
    bit tk;

    function automatic int nch(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    task automatic model_update();
        bit stp;
        int nx, ny;
        if (rst) begin
            cnt = 0;
            tk  = 0;
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 4; i++) begin
                    px[m][i] = 0; py[m][i] = 0; vx[m][i] = 0; vy[m][i] = 0;
                    act[m][i] = 0; ex[m][i] = 0;
                end
        end else begin
            stp = !halt && (cnt == TDIV - 1);
            tk  = stp;
            if (!halt) cnt = stp ? 0 : cnt + 1;
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < nch(m); i++) begin
                    ex[m][i] = 0;
                    if (kill[i]) begin
                        px[m][i] = 0; py[m][i] = 0; vx[m][i] = 0; vy[m][i] = 0;
                        act[m][i] = 0;
                    end else if (spawn && int'(sid) == i) begin
                        px[m][i] = (int'(sx) > XMAX) ? XMAX : int'(sx);
                        py[m][i] = (int'(sy) > YMAX) ? YMAX : int'(sy);
                        vx[m][i] = int'($signed(sdx));
                        vy[m][i] = int'($signed(sdy));
                        act[m][i] = 1;
                    end else if (act[m][i] && stp) begin
                        nx = px[m][i] + vx[m][i];
                        ny = py[m][i] + vy[m][i];
                        if (m == 0) begin
                            px[m][i] = ((nx % (XMAX + 1)) + XMAX + 1) % (XMAX + 1);
                            py[m][i] = ((ny % (YMAX + 1)) + YMAX + 1) % (YMAX + 1);
                        end else if (nx < 0 || nx > XMAX || ny < 0 || ny > YMAX) begin
                            px[m][i] = 0; py[m][i] = 0; act[m][i] = 0; ex[m][i] = 1;
                        end else begin
                            px[m][i] = nx; py[m][i] = ny;
                        end
                    end
                end
        end
    endtask

    function automatic logic [3:0] pk_act(input int m);
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++) v[i] = act[m][i];
        return v;
    endfunction

    function automatic logic [3:0] pk_ex(input int m);
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++) v[i] = ex[m][i];
        return v;
    endfunction

    function automatic logic [39:0] pk_x(input int m);
        logic [39:0] v = '0;
        for (int i = 0; i < 4; i++) v[i*10 +: 10] = 10'(px[m][i]);
        return v;
    endfunction

    function automatic logic [39:0] pk_y(input int m);
        logic [39:0] v = '0;
        for (int i = 0; i < 4; i++) v[i*10 +: 10] = 10'(py[m][i]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("A.active", 64'(ifa.active),   64'(pk_act(0)));
        chk("A.x_pos",  64'(ifa.x_pos),    64'(pk_x(0)));
        chk("A.y_pos",  64'(ifa.y_pos),    64'(pk_y(0)));
        chk("A.exit",   64'(ifa.exit_evt), 64'(pk_ex(0)));
        chk("A.tick",   64'(ifa.tick),     64'(tk));
        chk("B.active", 64'(ifb.active),   64'(pk_act(1)));
        chk("B.x_pos",  64'(ifb.x_pos),    64'(pk_x(1)));
        chk("B.y_pos",  64'(ifb.y_pos),    64'(pk_y(1)));
        chk("B.exit",   64'(ifb.exit_evt), 64'(pk_ex(1)));
        chk("B.tick",   64'(ifb.tick),     64'(tk));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 0; spawn = 0; kill = '0; sid = '0;
        sx = '0; sy = '0; sdx = '0; sdy = '0;
    endtask

    typedef struct {
        logic       rst;
        logic       sp;
        logic [1:0] id;
        logic [9:0] x, y;
        logic [3:0] dx, dy;
        logic [3:0] kl;
        int         idle;
        int         ch;
        logic [3:0] e_act;
        int         e_x, e_y;
    } vec_t;

    vec_t tbl[8];

    initial begin : main
        int n;
        bit seen;
        tbl[0] = '{1'b1, 1'b0, 2'd0, 10'd0,    10'd0,    4'h0, 4'h0, 4'b0000, 0,  0, 4'b0000, 0,   0};
        tbl[1] = '{1'b0, 1'b1, 2'd0, 10'd10,   10'd20,   4'h1, 4'hE, 4'b0000, 11, 0, 4'b0001, 13,  14};
        tbl[2] = '{1'b0, 1'b1, 2'd1, 10'd638,  10'd5,    4'h3, 4'h0, 4'b0000, 3,  1, 4'b0011, 1,   5};
        tbl[3] = '{1'b0, 1'b1, 2'd2, 10'd1,    10'd5,    4'hD, 4'h0, 4'b0000, 3,  2, 4'b0111, 638, 5};
        tbl[4] = '{1'b0, 1'b1, 2'd3, 10'd1000, 10'd1000, 4'h0, 4'h0, 4'b0000, 0,  3, 4'b1111, 639, 479};
        tbl[5] = '{1'b0, 1'b1, 2'd1, 10'd50,   10'd50,   4'h1, 4'h1, 4'b0010, 0,  1, 4'b1101, 0,   0};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 10'd0,    10'd0,    4'h0, 4'h0, 4'b0000, 0,  2, 4'b1101, 638, 5};
        tbl[7] = '{1'b0, 1'b1, 2'd2, 10'd100,  10'd100,  4'h5, 4'h5, 4'b0000, 0,  2, 4'b1101, 100, 100};

        idle_inputs();
        halt = 0;
        rst  = 1;

        for (int v = 0; v < 8; v++) begin
            rst = tbl[v].rst; spawn = tbl[v].sp; sid = tbl[v].id;
            sx = tbl[v].x; sy = tbl[v].y; sdx = tbl[v].dx; sdy = tbl[v].dy;
            kill = tbl[v].kl;
            step();
            idle_inputs();
            for (int k = 0; k < tbl[v].idle; k++) step();
            chk($sformatf("vec%0d.active", v), 64'(ifa.active), 64'(tbl[v].e_act));
            chk($sformatf("vec%0d.x", v), 64'(ifa.x_pos[tbl[v].ch*10 +: 10]), 64'(tbl[v].e_x));
            chk($sformatf("vec%0d.y", v), 64'(ifa.y_pos[tbl[v].ch*10 +: 10]), 64'(tbl[v].e_y));
            $display("vec %0d: ch%0d active=%b x=%0d y=%0d", v, tbl[v].ch,
                     ifa.active, ifa.x_pos[tbl[v].ch*10 +: 10], ifa.y_pos[tbl[v].ch*10 +: 10]);
        end
        chk("ch0.after_vecs.x", 64'(ifa.x_pos[9:0]), 64'(16));
        chk("ch0.after_vecs.y", 64'(ifa.y_pos[9:0]), 64'(8));

        // Halt for 10 cycles with the prescaler at 1, spawning id3 part way through
        step();
        halt = 1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                spawn = 1; sid = 2'd3; sx = 10'd50; sy = 10'd60; sdx = 4'h1; sdy = 4'h1;
            end
            step();
            idle_inputs();
            chk("halt.tick", 64'(ifa.tick), 64'(0));
        end
        halt = 0;
        chk("halt.spawn.active", 64'(ifa.active[3]), 64'(1));
        chk("halt.spawn.x", 64'(ifa.x_pos[39:30]), 64'(50));
        chk("halt.frozen.x", 64'(ifa.x_pos[9:0]), 64'(16));
        chk("halt.frozen.y", 64'(ifa.y_pos[9:0]), 64'(8));
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ifa.tick) begin n = k; break; end
        end
        chk("halt.resume_cycles", 64'(n), 64'(3));
        $display("halt: resumed tick after %0d cycles", n);

        // Retire on the retire instance: y leaves the top edge
        spawn = 1; sid = 2'd0; sx = 10'd2; sy = 10'd0; sdx = 4'h0; sdy = 4'hF;
        step();
        idle_inputs();
        seen = 0;
        for (int k = 0; k < 2 * TDIV + 2; k++) begin
            step();
            if (ifb.exit_evt[0]) begin seen = 1; break; end
        end
        chk("retire.seen", 64'(seen), 64'(1));
        chk("retire.active", 64'(ifb.active[0]), 64'(0));
        chk("retire.x", 64'(ifb.x_pos[9:0]), 64'(0));
        chk("retire.y", 64'(ifb.y_pos[9:0]), 64'(0));
        chk("wrap.y_top", 64'(ifa.y_pos[9:0]), 64'(479));
        step();
        chk("retire.pulse_width", 64'(ifb.exit_evt[0]), 64'(0));
        $display("retire: exit pulse seen=%0d", seen);

        // Reset with four live objects, then first tick TDIV cycles later
        for (int i = 0; i < 4; i++) begin
            spawn = 1; sid = 2'(i); sx = 10'(100 + 10 * i); sy = 10'd200;
            step();
        end
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        chk("reset.active", 64'(ifa.active), 64'(0));
        chk("reset.x", 64'(ifa.x_pos), 64'(0));
        chk("reset.y", 64'(ifa.y_pos), 64'(0));
        chk("reset.tick", 64'(ifa.tick), 64'(0));
        chk("reset.B.active", 64'(ifb.active), 64'(0));
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ifa.tick) begin n = k; break; end
        end
        chk("reset.first_tick", 64'(n), 64'(TDIV));
        $display("reset: first tick %0d cycles after release", n);

        // id 3 is out of range for the 3-channel instance
        spawn = 1; sid = 2'd3; sx = 10'd5; sy = 10'd5; sdx = 4'h1; sdy = 4'h1;
        step();
        idle_inputs();
        chk("B.id3_ignored", 64'(ifb.active), 64'(0));
        chk("A.id3_taken", 64'(ifa.active), 64'(4'b1000));
        $display("spawn id3: A active=%b B active=%b", ifa.active, ifb.active);

        // Randomised traffic, checked every cycle against the model
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            halt  = ($urandom_range(0, 7) == 0);
            spawn = ($urandom_range(0, 3) == 0);
            sid   = 2'($urandom_range(0, 3));
            sx    = 10'($urandom_range(0, 700));
            sy    = 10'($urandom_range(0, 520));
            sdx   = 4'($urandom);
            sdy   = 4'($urandom);
            kill  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            if (rst || spawn || kill != 0)
                $display("rand %0d: rst=%0d spawn=%0d id=%0d pos=(%0d,%0d) d=(%0d,%0d) kill=%b",
                         c, rst, spawn, sid, sx, sy, $signed(sdx), $signed(sdy), kill);
            step();
        end
        idle_inputs();
        halt = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
